uop_dispatch: RTL

UOP_DISPATCH -- requirements
Module: uop_dispatch

---
 rtl/uop_dispatch.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uop_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uop_dispatch                                                 |
// | Description : Micro-op queue with issue stage, operand forwarding and a    |
// |               width-merging register-file writeback.                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

`ifndef OPCODE_W
`define OPCODE_W 6
`endif
`ifndef IMM_W
`define IMM_W 32
`endif
`ifndef BIT_MODE_W
`define BIT_MODE_W 2
`endif
`ifndef REG_W
`define REG_W 64
`endif

module uop_dispatch #(
    parameter  int DEPTH = 4,
    parameter  int NREG  = 16,
    localparam int RI    = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   uop_valid,
    output logic                   uop_ready,
    input  logic [`OPCODE_W-1:0]   uop_opcode,
    input  logic [RI-1:0]          uop_rd,
    input  logic [RI-1:0]          uop_rs,
    input  logic [RI-1:0]          uop_rt,
    input  logic [`IMM_W-1:0]      uop_imm,
    input  logic [`BIT_MODE_W-1:0] uop_bit_mode,
    input  logic                   stall,
    output logic                   ex_valid,
    output logic [`OPCODE_W-1:0]   ex_opcode,
    output logic [`IMM_W-1:0]      ex_imm,
    output logic [`BIT_MODE_W-1:0] ex_bit_mode,
    output logic [`REG_W-1:0]      ex_s,
    output logic [`REG_W-1:0]      ex_t,
    input  logic [`REG_W-1:0]      ex_d,
    input  logic [RI-1:0]          dbg_idx,
    output logic [`REG_W-1:0]      dbg_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

    localparam logic [`OPCODE_W-1:0] MICRO_ADD  = `OPCODE_W'd1;
    localparam logic [`OPCODE_W-1:0] MICRO_ADDI = `OPCODE_W'd2;
    localparam logic [`OPCODE_W-1:0] MICRO_SUB  = `OPCODE_W'd3;
    localparam logic [`OPCODE_W-1:0] MICRO_SUBI = `OPCODE_W'd4;
    localparam logic [`OPCODE_W-1:0] MICRO_SLLI = `OPCODE_W'd5;
    localparam logic [`OPCODE_W-1:0] MICRO_AND  = `OPCODE_W'd6;
    localparam logic [`OPCODE_W-1:0] MICRO_ANDI = `OPCODE_W'd7;
    localparam logic [`OPCODE_W-1:0] MICRO_OR   = `OPCODE_W'd8;
    localparam logic [`OPCODE_W-1:0] MICRO_ORI  = `OPCODE_W'd9;
    localparam logic [`OPCODE_W-1:0] MICRO_XOR  = `OPCODE_W'd10;
    localparam logic [`OPCODE_W-1:0] MICRO_XORI = `OPCODE_W'd11;
    localparam logic [`OPCODE_W-1:0] MICRO_MOV  = `OPCODE_W'd12;
    localparam logic [`OPCODE_W-1:0] MICRO_MOVI = `OPCODE_W'd13;
    localparam logic [`OPCODE_W-1:0] MICRO_LEA  = `OPCODE_W'd14;

    localparam logic [`BIT_MODE_W-1:0] BIT_MODE_8  = `BIT_MODE_W'd0;
    localparam logic [`BIT_MODE_W-1:0] BIT_MODE_16 = `BIT_MODE_W'd1;
    localparam logic [`BIT_MODE_W-1:0] BIT_MODE_32 = `BIT_MODE_W'd2;

    function automatic logic f_writes(input logic [`OPCODE_W-1:0] op);
        logic w;
        case (op)
            MICRO_ADD, MICRO_ADDI, MICRO_SUB, MICRO_SUBI, MICRO_SLLI,
            MICRO_AND, MICRO_ANDI, MICRO_OR,  MICRO_ORI,  MICRO_XOR,
            MICRO_XORI, MICRO_MOV, MICRO_MOVI, MICRO_LEA: w = 1'b1;
            default:                                      w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic [`REG_W-1:0] f_merge(
        input logic [`REG_W-1:0]      old_v,
        input logic [`REG_W-1:0]      new_v,
        input logic [`BIT_MODE_W-1:0] mode
    );
        logic [`REG_W-1:0] m;
        case (mode)
            BIT_MODE_8:  m = {old_v[`REG_W-1:8],  new_v[7:0]};
            BIT_MODE_16: m = {old_v[`REG_W-1:16], new_v[15:0]};
            BIT_MODE_32: m = {{(`REG_W-32){1'b0}}, new_v[31:0]};
            default:     m = new_v;
        endcase
        return m;
    endfunction

    logic [`OPCODE_W-1:0]   r_q_opcode [DEPTH];
    logic [RI-1:0]          r_q_rd     [DEPTH];
    logic [RI-1:0]          r_q_rs     [DEPTH];
    logic [RI-1:0]          r_q_rt     [DEPTH];
    logic [`IMM_W-1:0]      r_q_imm    [DEPTH];
    logic [`BIT_MODE_W-1:0] r_q_mode   [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;

    logic [`REG_W-1:0]      r_rf [NREG];
    logic [RI-1:0]          r_ex_rd;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_ex_wr;
    logic [`REG_W-1:0]      w_merged;
    logic [RI-1:0]          w_head_rs;
    logic [RI-1:0]          w_head_rt;
    logic [`REG_W-1:0]      w_s;
    logic [`REG_W-1:0]      w_t;

    // A full queue refuses a push even when the head issues in the same cycle.
    assign uop_ready = (r_count != C_FULL_COUNT);
    assign w_push    = uop_valid && uop_ready;
    assign w_pop     = (r_count != '0) && !stall;

    assign w_ex_wr   = ex_valid && f_writes(ex_opcode);
    assign w_merged  = f_merge(r_rf[r_ex_rd], ex_d, ex_bit_mode);
    assign w_head_rs = r_q_rs[r_rd_ptr];
    assign w_head_rt = r_q_rt[r_rd_ptr];

    // The presented op's result lands in the register file at this same edge,
    // so the issuing op must take it from the bypass instead.
    assign w_s = (w_ex_wr && (r_ex_rd == w_head_rs)) ? w_merged : r_rf[w_head_rs];
    assign w_t = (w_ex_wr && (r_ex_rd == w_head_rt)) ? w_merged : r_rf[w_head_rt];

    assign dbg_data = r_rf[dbg_idx];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_opcode[r_wr_ptr] <= uop_opcode;
            r_q_rd[r_wr_ptr]     <= uop_rd;
            r_q_rs[r_wr_ptr]     <= uop_rs;
            r_q_rt[r_wr_ptr]     <= uop_rt;
            r_q_imm[r_wr_ptr]    <= uop_imm;
            r_q_mode[r_wr_ptr]   <= uop_bit_mode;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_imm      <= '0;
            ex_bit_mode <= '0;
            ex_s        <= '0;
            ex_t        <= '0;
            r_ex_rd     <= '0;
        end else begin
            ex_valid <= w_pop;
            if (w_pop) begin
                ex_opcode   <= r_q_opcode[r_rd_ptr];
                ex_imm      <= r_q_imm[r_rd_ptr];
                ex_bit_mode <= r_q_mode[r_rd_ptr];
                ex_s        <= w_s;
                ex_t        <= w_t;
                r_ex_rd     <= r_q_rd[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_ex_wr) begin
            r_rf[r_ex_rd] <= w_merged;
        end
    end

endmodule

`default_nettype wire
